ifu_line_server: RTL and testbench

- Responder side of the IFU ↔ i-cache read interface.
- Accepts a line read request and the fetch PC from the IFU.
- Fetches the aligned instruction line from memory in BUS_W-wide beats, one beat outstanding at a time.
- Returns the line, its PC and an exception status with a one-cycle read_done pulse. Sits between the IFU and the instruction memory port.

---
 rtl/ifu_line_server_if.sv | 43 ++++
 rtl/ifu_line_server.sv | 158 +++++++++++++++
 tb/tb_ifu_line_server.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_line_server_if.sv
// IFU request/response and instruction-memory beat handshakes.
// slave: the line server; master: the IFU plus memory side.
interface ifu_line_server_if #(
    parameter int XLEN   = 64,
    parameter int LINE_W = 128,
    parameter int BUS_W  = 64
);
    logic              flush_i;
    logic              read_req_i;
    logic [XLEN-1:0]   pc_i;
    logic              read_done_o;
    logic [LINE_W-1:0] line_o;
    logic [XLEN-1:0]   line_pc_o;
    logic              except_o;
    logic [1:0]        except_code_o;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [XLEN-1:0]   mem_req_addr_o;
    logic              mem_ans_valid_i;
    logic              mem_ans_ready_o;
    logic [BUS_W-1:0]  mem_ans_data_i;
    logic              mem_ans_err_i;

    modport slave (
        input  flush_i, read_req_i, pc_i,
        input  mem_req_ready_i, mem_ans_valid_i,
        input  mem_ans_data_i, mem_ans_err_i,
        output read_done_o, line_o, line_pc_o,
        output except_o, except_code_o,
        output mem_req_valid_o, mem_req_addr_o,
        output mem_ans_ready_o
    );

    modport master (
        output flush_i, read_req_i, pc_i,
        output mem_req_ready_i, mem_ans_valid_i,
        output mem_ans_data_i, mem_ans_err_i,
        input  read_done_o, line_o, line_pc_o,
        input  except_o, except_code_o,
        input  mem_req_valid_o, mem_req_addr_o,
        input  mem_ans_ready_o
    );
endinterface

// File: rtl/ifu_line_server.sv
// Fetches an aligned instruction line in BUS_W beats for the IFU.
// Define IFU_LINE_REUSE_EN to serve repeat requests from the last line.
module ifu_line_server #(
    parameter int XLEN   = 64,
    parameter int LINE_W = 128,
    parameter int BUS_W  = 64
) (
    input logic clk_i,
    input logic rst_ni,
    ifu_line_server_if.slave bus
);
    localparam int BEATS      = LINE_W / BUS_W;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int KW         = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [KW-1:0]   K_LAST = KW'(BEATS - 1);
    localparam logic [XLEN-1:0] STEP   = XLEN'(BUS_W / 8);
    localparam logic [XLEN-1:0] ALIGN  = {XLEN{1'b1}} << OFF_W;
    localparam logic [1:0]      EXC_NONE   = 2'd0;
    localparam logic [1:0]      EXC_ACCESS = 2'd2;

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, DONE, DRAIN
    } state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic [XLEN-1:0]   base;
    logic [LINE_W-1:0] acc_line;
    logic [LINE_W-1:0] fill;
    logic [XLEN-1:0]   pc_al;
    logic              done_q;
    logic              req_vld;
    logic              ans_rdy;
    logic              exc;
    logic [1:0]        code;
    logic [LINE_W-1:0] line;
    logic [XLEN-1:0]   line_pc;
    logic [XLEN-1:0]   addr;
`ifdef IFU_LINE_REUSE_EN
    logic              line_vld;
`endif

    assign pc_al = bus.pc_i & ALIGN;

    // Later beats stay zero from the clear at accept, so an error
    // beat leaves the rest of the line zeroed.
    always_comb begin
        fill = acc_line;
        fill[int'(k)*BUS_W +: BUS_W] = bus.mem_ans_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            k        <= '0;
            base     <= '0;
            acc_line <= '0;
            done_q   <= 1'b0;
            req_vld  <= 1'b0;
            ans_rdy  <= 1'b0;
            exc      <= 1'b0;
            code     <= EXC_NONE;
            line     <= '0;
            line_pc  <= '0;
            addr     <= '0;
`ifdef IFU_LINE_REUSE_EN
            line_vld <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.flush_i) begin
                exc     <= 1'b0;
                code    <= EXC_NONE;
                req_vld <= 1'b0;
`ifdef IFU_LINE_REUSE_EN
                line_vld <= 1'b0;
`endif
                // An accepted address still owes one answer: drain it.
                unique case (state)
                    ADDR: begin
                        state   <= bus.mem_req_ready_i ? DRAIN : IDLE;
                        ans_rdy <= bus.mem_req_ready_i;
                    end
                    DATA, DRAIN: begin
                        state   <= bus.mem_ans_valid_i ? IDLE : DRAIN;
                        ans_rdy <= ~bus.mem_ans_valid_i;
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                unique case (state)
                    IDLE: if (bus.read_req_i) begin
                        base     <= pc_al;
                        k        <= '0;
                        acc_line <= '0;
`ifdef IFU_LINE_REUSE_EN
                        if (line_vld && pc_al == line_pc) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ADDR;
                            req_vld <= 1'b1;
                            addr    <= pc_al;
                        end
`else
                        state   <= ADDR;
                        req_vld <= 1'b1;
                        addr    <= pc_al;
`endif
                    end
                    ADDR: if (bus.mem_req_ready_i) begin
                        state   <= DATA;
                        req_vld <= 1'b0;
                        ans_rdy <= 1'b1;
                    end
                    DATA: if (bus.mem_ans_valid_i) begin
                        ans_rdy <= 1'b0;
                        if (bus.mem_ans_err_i || k == K_LAST) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            line    <= fill;
                            line_pc <= base;
                            exc     <= bus.mem_ans_err_i;
                            code    <= bus.mem_ans_err_i ? EXC_ACCESS : EXC_NONE;
`ifdef IFU_LINE_REUSE_EN
                            line_vld <= ~bus.mem_ans_err_i;
`endif
                        end else begin
                            acc_line <= fill;
                            k        <= k + 1'b1;
                            addr     <= addr + STEP;
                            req_vld  <= 1'b1;
                            state    <= ADDR;
                        end
                    end
                    DONE: state <= IDLE;
                    DRAIN: if (bus.mem_ans_valid_i) begin
                        state   <= IDLE;
                        ans_rdy <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A flush landing on the DONE cycle must swallow the pulse.
    assign bus.read_done_o     = done_q & ~bus.flush_i;
    assign bus.line_o          = line;
    assign bus.line_pc_o       = line_pc;
    assign bus.except_o        = exc;
    assign bus.except_code_o   = code;
    assign bus.mem_req_valid_o = req_vld;
    assign bus.mem_req_addr_o  = addr;
    assign bus.mem_ans_ready_o = ans_rdy;
endmodule

// File: tb/tb_ifu_line_server.sv
// Bench for ifu_line_server: vector table, memory model, scoreboard.
// Covers fetch, stalls, errors, flush corners and optional line reuse.
module tb_ifu_line_server;
    localparam int XLEN   = 64;
    localparam int LINE_W = 128;
    localparam int BUS_W  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_line_server_if #(
        .XLEN(XLEN), .LINE_W(LINE_W), .BUS_W(BUS_W)
    ) bus ();

    ifu_line_server #(
        .XLEN(XLEN), .LINE_W(LINE_W), .BUS_W(BUS_W)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0]  pc;
        int           rw;
        int           aw;
        logic         err_en;
        logic [63:0]  err_addr;
        logic [127:0] line;
        logic [63:0]  lpc;
        logic         exc;
        logic [1:0]   code;
        int           lat;
        int           nreq;
    } vec_t;

    typedef struct {
        logic [127:0] line;
        logic [63:0]  lpc;
        logic         exc;
        logic [1:0]   code;
        int           due;
    } exp_t;

    localparam logic [127:0] LINE_AB =
        128'hBBBB_BBBB_BBBB_BBBB_AAAA_AAAA_AAAA_AAAA;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int rw = 0;
    int aw = 0;
    int nreq = 0;
    int nans = 0;
    logic err_en = 1'b0;
    logic [63:0] err_addr = '0;
    logic [63:0] addr_log[$];
    exp_t sb[$];
    vec_t vt[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mw(input logic [63:0] a);
        if (a == 64'h1000) return {16{4'hA}};
        if (a == 64'h1008) return {16{4'hB}};
        return {a[31:0] ^ 32'h5A5A_5A5A, a[31:0]};
    endfunction

    // Memory: one outstanding beat, rw stall cycles before ready,
    // aw cycles before the answer.
    initial begin : mem_model
        logic pend, rdy, avl, svld, sardy;
        logic [63:0] paddr, saddr, hold_addr;
        int rc, ac;
        pend = 0; rdy = 0; avl = 0; svld = 0; sardy = 0;
        paddr = '0; saddr = '0; hold_addr = '0; rc = 0; ac = 0;
        bus.mem_req_ready_i = 1'b0;
        bus.mem_ans_valid_i = 1'b0;
        bus.mem_ans_data_i  = '0;
        bus.mem_ans_err_i   = 1'b0;
        forever begin
            @(negedge clk);
            if (avl && sardy) begin
                pend = 0;
                nans++;
            end
            if (rdy && svld) begin
                pend = 1;
                paddr = saddr;
                ac = 0;
                nreq++;
                addr_log.push_back(saddr);
            end
            svld  = bus.mem_req_valid_o;
            sardy = bus.mem_ans_ready_o;
            saddr = bus.mem_req_addr_o;
            rdy = 0;
            if (svld && !pend) begin
                if (rc == 0) hold_addr = saddr;
                else chk("addr_stable", 128'(saddr), 128'(hold_addr));
                if (rc >= rw) begin
                    rdy = 1;
                    rc = 0;
                end else rc++;
            end else rc = 0;
            avl = 0;
            if (pend) begin
                if (ac >= aw) avl = 1;
                else ac++;
            end
            bus.mem_req_ready_i = rdy;
            bus.mem_ans_valid_i = avl;
            bus.mem_ans_data_i  = avl ? mw(paddr) : '0;
            bus.mem_ans_err_i   = avl && err_en && (paddr == err_addr);
        end
    end

    // Scoreboard: every read_done_o pops one expected line.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.read_done_o === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("line", bus.line_o, e.line);
                    chk("line_pc", 128'(bus.line_pc_o), 128'(e.lpc));
                    chk("except", 128'(bus.except_o), 128'(e.exc));
                    chk("code", 128'(bus.except_code_o), 128'(e.code));
                    chk("latency", 128'(cyc), 128'(e.due));
                end
            end
        end
    end

    task automatic run_fetch(input vec_t v);
        int n0;
        bit seen;
        rw = v.rw;
        aw = v.aw;
        err_en = v.err_en;
        err_addr = v.err_addr;
        addr_log.delete();
        n0 = nreq;
        @(negedge clk);
        bus.read_req_i = 1'b1;
        bus.pc_i = v.pc;
        sb.push_back('{line: v.line, lpc: v.lpc, exc: v.exc,
                       code: v.code, due: cyc + v.lat});
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.read_done_o) seen = 1;
        end
        bus.read_req_i = 1'b0;
        chk("done_seen", 128'(seen), 128'(1));
        if (!seen && sb.size() > 0) void'(sb.pop_back());
        chk("mem_reqs", 128'(nreq - n0), 128'(v.nreq));
        for (int i = 0; i < addr_log.size(); i++)
            chk("beat_addr", 128'(addr_log[i]), 128'(v.lpc + 64'(8 * i)));
    endtask

    task automatic flush_seq(input string nm, input logic [63:0] pc,
                             input int w_rw, input int w_aw,
                             input bit on_data, input bit exp_rdy,
                             input int exp_req, input int exp_ans);
        int n0, a0;
        bit got;
        rw = w_rw;
        aw = w_aw;
        err_en = 1'b0;
        n0 = nreq;
        a0 = nans;
        @(negedge clk);
        bus.read_req_i = 1'b1;
        bus.pc_i = pc;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (on_data ? bus.mem_ans_ready_o : bus.mem_req_valid_o) got = 1;
        end
        chk({nm, "_reach"}, 128'(got), 128'(1));
        bus.flush_i = 1'b1;
        bus.read_req_i = 1'b0;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk({nm, "_req_drop"}, 128'(bus.mem_req_valid_o), 128'(0));
        chk({nm, "_ans_rdy"}, 128'(bus.mem_ans_ready_o), 128'(exp_rdy));
        chk({nm, "_except"}, 128'(bus.except_o), 128'(0));
        chk({nm, "_code"}, 128'(bus.except_code_o), 128'(0));
        repeat (12) @(negedge clk);
        chk({nm, "_nreq"}, 128'(nreq - n0), 128'(exp_req));
        chk({nm, "_nans"}, 128'(nans - a0), 128'(exp_ans));
        chk({nm, "_idle"}, 128'(bus.mem_ans_ready_o), 128'(0));
    endtask

    initial begin : main
        vec_t v;
        int n0;
        bus.flush_i = 1'b0;
        bus.read_req_i = 1'b0;
        bus.pc_i = '0;

        vt[0] = '{pc: 64'h1008, rw: 0, aw: 0, err_en: 0, err_addr: 0,
                  line: LINE_AB, lpc: 64'h1000, exc: 0, code: 0,
                  lat: 5, nreq: 2};
        vt[1] = '{pc: 64'h2000, rw: 0, aw: 0, err_en: 1, err_addr: 64'h2000,
                  line: {64'h0, mw(64'h2000)}, lpc: 64'h2000, exc: 1, code: 2,
                  lat: 3, nreq: 1};
        vt[2] = '{pc: 64'h1008, rw: 3, aw: 2, err_en: 0, err_addr: 0,
                  line: LINE_AB, lpc: 64'h1000, exc: 0, code: 0,
                  lat: 15, nreq: 2};
        vt[3] = '{pc: 64'h4010, rw: 1, aw: 0, err_en: 1, err_addr: 64'h4018,
                  line: {mw(64'h4018), mw(64'h4010)}, lpc: 64'h4010,
                  exc: 1, code: 2, lat: 7, nreq: 2};
        vt[4] = '{pc: 64'hFFFF_FFFF_FFFF_FFFF, rw: 0, aw: 1, err_en: 0,
                  err_addr: 0,
                  line: {mw(64'hFFFF_FFFF_FFFF_FFF8), mw(64'hFFFF_FFFF_FFFF_FFF0)},
                  lpc: 64'hFFFF_FFFF_FFFF_FFF0, exc: 0, code: 0,
                  lat: 7, nreq: 2};

        repeat (3) @(negedge clk);
        chk("rst_done", 128'(bus.read_done_o), 128'(0));
        chk("rst_line", bus.line_o, 128'(0));
        chk("rst_pc", 128'(bus.line_pc_o), 128'(0));
        chk("rst_exc", 128'(bus.except_o), 128'(0));
        chk("rst_code", 128'(bus.except_code_o), 128'(0));
        chk("rst_req_vld", 128'(bus.mem_req_valid_o), 128'(0));
        chk("rst_addr", 128'(bus.mem_req_addr_o), 128'(0));
        chk("rst_ans_rdy", 128'(bus.mem_ans_ready_o), 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_fetch(vt[i]);

        v = '{pc: 64'h6008, rw: 0, aw: 0, err_en: 1, err_addr: 64'h6000,
              line: {64'h0, mw(64'h6000)}, lpc: 64'h6000, exc: 1, code: 2,
              lat: 3, nreq: 1};
        run_fetch(v);
        repeat (3) @(negedge clk);
        chk("hold_exc", 128'(bus.except_o), 128'(1));
        chk("hold_code", 128'(bus.except_code_o), 128'(2));
        chk("hold_pc", 128'(bus.line_pc_o), 128'(64'h6000));

        flush_seq("fl_addr", 64'h8000, 5, 0, 0, 0, 0, 0);
        flush_seq("fl_hs", 64'h7000, 0, 0, 0, 1, 1, 1);
        flush_seq("fl_data", 64'h5000, 0, 4, 1, 1, 1, 1);
        v = '{pc: 64'h3000, rw: 0, aw: 0, err_en: 0, err_addr: 0,
              line: {mw(64'h3008), mw(64'h3000)}, lpc: 64'h3000,
              exc: 0, code: 0, lat: 5, nreq: 2};
        run_fetch(v);
        flush_seq("fl_data_vld", 64'h5100, 0, 0, 1, 0, 1, 1);

        n0 = nreq;
        @(negedge clk);
        bus.read_req_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.pc_i = 64'h9000;
        @(negedge clk);
        bus.read_req_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("req_on_flush", 128'(bus.mem_req_valid_o), 128'(0));
        repeat (4) @(negedge clk);
        chk("req_on_flush_nreq", 128'(nreq - n0), 128'(0));

`ifdef IFU_LINE_REUSE_EN
        v = '{pc: 64'h1000, rw: 0, aw: 0, err_en: 0, err_addr: 0,
              line: LINE_AB, lpc: 64'h1000, exc: 0, code: 0,
              lat: 5, nreq: 2};
        run_fetch(v);
        v.pc = 64'h100C;
        v.lat = 1;
        v.nreq = 0;
        run_fetch(v);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        v.lat = 5;
        v.nreq = 2;
        run_fetch(v);
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
